versatile_fifo_mc_sc: RTL and testbench

//  Multi-channel FIFO. 2**CH_ADDR_WIDTH independent channels share one dual-port RAM
//  (write port and read port, both on clk).

---
 rtl/versatile_fifo_mc_sc.sv | 121 ++++++++++++
 tb/tb_versatile_fifo_mc_sc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/versatile_fifo_mc_sc.sv
// Multi-channel FIFO: 2**CH_ADDR_WIDTH independent channels sharing one dual-port RAM.
// Per-channel flags, fill level, flush and sticky overflow/underflow; single clock domain.
module versatile_fifo_mc_sc #(
  parameter int DATA_WIDTH    = 8,
  parameter int CH_ADDR_WIDTH = 2,
  parameter int DEPTH_LOG2    = 9,
  parameter int AFULL_LEVEL   = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_LEVEL  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CH_ADDR_WIDTH-1:0]        wr_ch,
  input  logic [DATA_WIDTH-1:0]           wr_dat,
  input  logic                            wr_en,
  input  logic [CH_ADDR_WIDTH-1:0]        rd_ch,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_dat,
  output logic                            rd_vld,
  input  logic [(1<<CH_ADDR_WIDTH)-1:0]   flush,
  input  logic [CH_ADDR_WIDTH-1:0]        level_ch,
  output logic [DEPTH_LOG2:0]             level,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   fifo_full,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   fifo_empty,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   almost_full,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   almost_empty,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   overflow,
  output logic [(1<<CH_ADDR_WIDTH)-1:0]   underflow
);

  localparam int N     = 1 << CH_ADDR_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int AW    = CH_ADDR_WIDTH + DEPTH_LOG2;

  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT   = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AE_CNT   = PW'(AEMPTY_LEVEL);

  if (AFULL_LEVEL <= 0 || AFULL_LEVEL > DEPTH || AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= DEPTH)
  begin : g_param_check
    $error("versatile_fifo_mc_sc: illegal AFULL_LEVEL/AEMPTY_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem [N*DEPTH];
  logic [PW-1:0]         wptr  [N];
  logic [PW-1:0]         rptr  [N];
  logic [PW-1:0]         count [N];

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Acceptance is judged on pre-edge flags, so same-address RAM collisions cannot occur.
  assign wr_acc  = wr_en & ~fifo_full[wr_ch]  & ~flush[wr_ch];
  assign rd_acc  = rd_en & ~fifo_empty[rd_ch] & ~flush[rd_ch];
  assign wr_addr = {wr_ch, wptr[wr_ch][DEPTH_LOG2-1:0]};
  assign rd_addr = {rd_ch, rptr[rd_ch][DEPTH_LOG2-1:0]};
  assign level   = count[level_ch];

  always_comb begin
    count        = '{default: '0};
    fifo_empty   = '0;
    fifo_full    = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int unsigned ch = 0; ch < N; ch++) begin
      count[ch]        = wptr[ch] - rptr[ch];
      fifo_empty[ch]   = (count[ch] == '0);
      fifo_full[ch]    = (count[ch] == FULL_CNT);
      almost_full[ch]  = (count[ch] >= AF_CNT);
      almost_empty[ch] = (count[ch] <= AE_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < N; ch++) begin
        wptr[ch] <= '0;
        rptr[ch] <= '0;
      end
      overflow  <= '0;
      underflow <= '0;
    end else begin
      for (int unsigned ch = 0; ch < N; ch++) begin
        if (flush[ch]) begin
          // Flush empties the channel by catching the read pointer up to the write pointer.
          rptr[ch]      <= wptr[ch];
          overflow[ch]  <= 1'b0;
          underflow[ch] <= 1'b0;
        end else begin
          if (wr_acc && wr_ch == CH_ADDR_WIDTH'(ch))
            wptr[ch] <= wptr[ch] + 1'b1;
          if (rd_acc && rd_ch == CH_ADDR_WIDTH'(ch))
            rptr[ch] <= rptr[ch] + 1'b1;
          if (wr_en && wr_ch == CH_ADDR_WIDTH'(ch) && fifo_full[ch])
            overflow[ch] <= 1'b1;
          if (rd_en && rd_ch == CH_ADDR_WIDTH'(ch) && fifo_empty[ch])
            underflow[ch] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc)
        rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_versatile_fifo_mc_sc.sv
// Directed bench for versatile_fifo_mc_sc: queue-per-channel model with a read-data
// scoreboard, flags and level checked after every clock step.
module tb_versatile_fifo_mc_sc;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int DL = 9;
  localparam int NC = 4;
  localparam int DEPTH = 512;
  localparam int AF = 508;
  localparam int AE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CW-1:0]     wr_ch;
  logic [DW-1:0]     wr_dat;
  logic              wr_en;
  logic [CW-1:0]     rd_ch;
  logic              rd_en;
  logic [DW-1:0]     rd_dat;
  logic              rd_vld;
  logic [NC-1:0]     flush;
  logic [CW-1:0]     level_ch;
  logic [DL:0]       level;
  logic [NC-1:0]     fifo_full;
  logic [NC-1:0]     fifo_empty;
  logic [NC-1:0]     almost_full;
  logic [NC-1:0]     almost_empty;
  logic [NC-1:0]     overflow;
  logic [NC-1:0]     underflow;

  versatile_fifo_mc_sc #(
    .DATA_WIDTH(DW), .CH_ADDR_WIDTH(CW), .DEPTH_LOG2(DL),
    .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_ch(wr_ch), .wr_dat(wr_dat), .wr_en(wr_en),
    .rd_ch(rd_ch), .rd_en(rd_en), .rd_dat(rd_dat), .rd_vld(rd_vld), .flush(flush),
    .level_ch(level_ch), .level(level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mq [NC][$];
  logic [DW-1:0] exp_q [$];
  logic [NC-1:0] m_ovf = '0;
  logic [NC-1:0] m_udf = '0;
  logic [DW-1:0] last_dat = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    logic [NC-1:0] e, f, af, ae;
    for (int c = 0; c < NC; c++) begin
      e[c]  = (mq[c].size() == 0);
      f[c]  = (mq[c].size() == DEPTH);
      af[c] = (mq[c].size() >= AF);
      ae[c] = (mq[c].size() <= AE);
    end
    chk("fifo_empty", 32'(fifo_empty), 32'(e));
    chk("fifo_full", 32'(fifo_full), 32'(f));
    chk("almost_full", 32'(almost_full), 32'(af));
    chk("almost_empty", 32'(almost_empty), 32'(ae));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("level", 32'(level), 32'(mq[level_ch].size()));
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    exp_q.delete();
    m_ovf = '0;
    m_udf = '0;
    last_dat = '0;
  endtask

  // One clock: drive inputs, predict from pre-edge model state, then check after the edge.
  task automatic step(input bit we, input int wc, input logic [DW-1:0] wd,
                      input bit re, input int rc, input logic [NC-1:0] fl);
    bit wacc, racc;
    logic [DW-1:0] d;
    wr_en = we; wr_ch = CW'(wc); wr_dat = wd;
    rd_en = re; rd_ch = CW'(rc); flush = fl;
    wacc = we && (mq[wc].size() < DEPTH) && !fl[wc];
    racc = re && (mq[rc].size() != 0) && !fl[rc];
    if (we && mq[wc].size() == DEPTH && !fl[wc]) m_ovf[wc] = 1'b1;
    if (re && mq[rc].size() == 0 && !fl[rc]) m_udf[rc] = 1'b1;
    if (racc) exp_q.push_back(mq[rc].pop_front());
    if (wacc) mq[wc].push_back(wd);
    for (int c = 0; c < NC; c++)
      if (fl[c]) begin
        mq[c].delete();
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end
    @(posedge clk);
    #1;
    chk("rd_vld", 32'(rd_vld), 32'(racc));
    if (racc) begin
      d = exp_q.pop_front();
      chk("rd_dat", 32'(rd_dat), 32'(d));
      last_dat = d;
    end else begin
      chk("rd_dat_hold", 32'(rd_dat), 32'(last_dat));
    end
    check_flags();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_dat = '0;
    rd_en = 1'b0; rd_ch = '0; flush = '0; level_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(fifo_empty), 32'hf);
    chk("rst_rd_vld", 32'(rd_vld), 32'h0);
    chk("rst_rd_dat", 32'(rd_dat), 32'h0);
    check_flags();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a write burst to ch0.
    for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h10 + i), 0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_empty", 32'(fifo_empty), 32'hf);
    chk("async_rst_vld", 32'(rd_vld), 32'h0);
    chk("async_rst_level", 32'(level), 32'h0);
    wr_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, '0, 1, 0, '0);
    chk("post_rst_udf0", 32'(underflow[0]), 32'h1);
    step(0, 0, '0, 0, 0, 4'b0001);

    // Fill ch2 to full plus one overflowing write, then drain in order.
    level_ch = 2'd2;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 2, DW'(i), 0, 0, '0);
      if (i == AF - 2) chk("af_at_507", 32'(almost_full[2]), 32'h0);
      if (i == AF - 1) chk("af_at_508", 32'(almost_full[2]), 32'h1);
    end
    step(1, 2, 8'hAA, 0, 0, '0);
    chk("ch2_full", 32'(fifo_full[2]), 32'h1);
    chk("ch2_level", 32'(level), 32'd512);
    chk("ch2_ovf", 32'(overflow[2]), 32'h1);
    chk("others_empty", 32'(fifo_empty & 4'b1011), 32'hb);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, '0, 1, 2, '0);
      if (i == 506) chk("ae_at_5", 32'(almost_empty[2]), 32'h0);
      if (i == 507) chk("ae_at_4", 32'(almost_empty[2]), 32'h1);
    end
    step(0, 0, '0, 0, 0, 4'b0100);

    // Interleaved traffic: prefill ch1, write ch0 / read ch1, then reverse so ch1 wptr wraps.
    level_ch = 2'd1;
    for (int i = 0; i < 256; i++) step(1, 1, DW'($urandom), 0, 0, '0);
    for (int i = 0; i < 500; i++)
      step(1, 0, DW'($urandom), mq[1].size() != 0, 1, '0);
    level_ch = 2'd0;
    for (int i = 0; i < 500; i++) step(1, 1, DW'($urandom), 1, 0, '0);
    step(0, 0, '0, 0, 0, 4'b0011);

    // Same-cycle write and read on ch1.
    level_ch = 2'd1;
    step(1, 1, 8'h5A, 0, 0, '0);
    step(1, 1, 8'hC3, 1, 1, '0);
    chk("wr_rd_old_dat", 32'(rd_dat), 32'h5A);
    chk("wr_rd_level1", 32'(level), 32'd1);
    step(0, 0, '0, 1, 1, '0);
    chk("wr_rd_second", 32'(rd_dat), 32'hC3);
    step(1, 1, 8'h77, 1, 1, '0);
    chk("empty_wr_rd_vld", 32'(rd_vld), 32'h0);
    chk("empty_wr_rd_udf", 32'(underflow[1]), 32'h1);
    chk("empty_wr_rd_lvl", 32'(level), 32'd1);

    // Flush ch3 with pending underflow, 10 entries and a same-cycle write.
    level_ch = 2'd3;
    step(0, 0, '0, 1, 3, '0);
    for (int i = 0; i < 10; i++) step(1, 3, DW'(8'hE0 + i), 0, 0, '0);
    chk("ch3_level10", 32'(level), 32'd10);
    step(1, 3, 8'hFF, 0, 0, 4'b1000);
    chk("flush_empty3", 32'(fifo_empty[3]), 32'h1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_udf3", 32'(underflow[3]), 32'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
